riscv_arb_mux: RTL and testbench
================================

# riscv_arb_mux

Parametrised N-channel selector for the RISC-V core datapath. It generalises the 4:1 operand mux to NCH valid/ready input channels feeding one registered valid/ready output. Three selection modes are supported: externally steered, fixed priority, and round-robin. It sits between producers that share one consumer port, such as writeback sources or a shared memory request port, and decouples them with one output register stage at full throughput.

## Interface
- XLEN, 32, data width per channel (shared core parameter)
- NCH, 4, number of input channels, ≥2
- MODE, 0, selection mode: 0 = steered by i_sel, 1 = fixed priority (lowest index wins), 2 = round-robin
- SELW, $clog2(NCH), channel index width (derived, not overridden)

Ports:
- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  reset; one clock, synchronous, active-high
- i_valid  in  NCH  per-channel request valid
- o_ready  out  NCH  per-channel accept; a channel transfers when i_valid[k] && o_ready[k]
- i_data  in  NCH*XLEN  flat channel data; channel k at [k*XLEN +: XLEN]
- i_sel  in  SELW  channel steer, MODE 0 only
- o_valid  out  1  output register holds data
- i_ready  in  1  consumer accept; output transfers when o_valid && i_ready
- o_data  out  XLEN  registered selected data
- o_idx  out  SELW  index of the channel that produced o_data

## Operation
- can_load = !o_valid || i_ready.
- Candidate set per mode:
  - MODE 0: only channel i_sel. If i_sel ≥ NCH, there is no candidate.
  - MODE 1: lowest-index channel with i_valid set.
  - MODE 2: first valid channel searching upward from pointer rr_ptr, wrapping NCH-1→0.
- grant is one-hot or zero. o_ready[k] = grant[k] && can_load. At most one o_ready bit is ever set.
- On a transfer from channel k: o_data ← i_data[k], o_idx ← k, o_valid ← 1.
- If can_load and there is no grant: o_valid ← 0 when i_ready, otherwise hold.
- If !can_load: o_data, o_idx and o_valid hold, and all o_ready bits are 0 (stall, no data loss).
- Round-robin pointer: on a transfer from k, rr_ptr ← (k+1) mod NCH; otherwise it holds. rr_ptr is unused in modes 0 and 1.
- Non-granted channels are never dropped. They keep asserting i_valid, and upstream must hold i_data stable until accepted.
- Reset: o_valid=0, o_data=0, o_idx=0, rr_ptr=0, o_ready=0 during the reset cycle.
- Reset asserted mid-transfer: the registered entry is discarded and no channel is acked in that cycle.

## Timing
- Latency: 1 cycle from input acceptance to o_valid.
- Throughput: 1 transfer per cycle when i_ready is held high.
- o_ready is combinational from i_valid, i_sel, rr_ptr, o_valid and i_ready. There is no combinational path from i_data to any output.
- Simultaneous events:
  - Output drain and new load in the same cycle are legal. The register is replaced back-to-back with no bubble.
  - If all NCH channels are valid in MODE 2, each is served exactly once in NCH consecutive transfers.
- Wrap-around: rr_ptr = NCH-1 with only channel 0 valid grants channel 0, and rr_ptr becomes 1.
- i_sel changes take effect in the same cycle; i_sel is not registered.

## Structure
- Mode encodings (MUX_MODE_STEER=0, MUX_MODE_PRIO=1, MUX_MODE_RR=2) belong in the shared core parameter include alongside XLEN.
- Sub-module riscv_rr_pick (combinational) computes a one-hot grant from a valid vector and a start pointer. MODE 1 uses it with start pointer 0; MODE 2 uses it with rr_ptr.
- The top level holds the output register, rr_ptr and the handshake logic.

## Test plan
- Reset: assert i_rst for 2 cycles with all i_valid=1 → o_valid=0, o_data=0, o_idx=0, o_ready=0; the first grant after release goes to channel 0 (MODE 1/2).
- MODE 0, NCH=4, i_sel=2, i_valid=4'b1111, channel k data 0x1000+k, i_ready=1 → only o_ready[2]=1; the next cycle gives o_data=0x1002, o_idx=2. With i_sel=2 and i_valid[2]=0 → o_valid drops to 0 after the drain.
- MODE 1, i_valid=4'b1010 → channel 1 granted every cycle while it stays valid. Drop i_valid[1] → channel 3 is granted.
- MODE 2, i_valid=4'b1111 held, i_ready=1 → o_idx sequence 0,1,2,3,0,…, one transfer per cycle with no bubbles.
- Backpressure: hold i_ready=0 for 3 cycles with o_valid=1 → o_data/o_idx are stable and o_ready=0. Release → the stalled entry drains and a new entry loads in the same cycle.
- Wrap-around: MODE 2, rr_ptr driven to 3 by serving channel 2, then i_valid=4'b0001 → channel 0 is granted and rr_ptr=1.

Source files
------------

// File: rtl/riscv_arb_mux_pkg.sv
// Shared core parameters for the datapath channel selector: default data
// width, the selection-mode encodings and a small index helper.
package riscv_arb_mux_pkg;

    localparam int CORE_XLEN = 32;

    localparam int MUX_MODE_STEER = 0;
    localparam int MUX_MODE_PRIO  = 1;
    localparam int MUX_MODE_RR    = 2;

    // Next channel index after idx, wrapping from nch-1 back to 0.
    function automatic int wrapInc(input int idx, input int nch);
        return (idx >= nch - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/riscv_arb_mux_rr_pick.sv
// Combinational rotating priority picker: grants the first set bit of
// valid found by searching upward from start, wrapping NCH-1 to 0.
// With start tied to zero it degenerates to a plain lowest-index picker.
module riscv_rr_pick
    import riscv_arb_mux_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int SELW = $clog2(NCH)
) (
    input  logic [NCH-1:0]  valid,
    input  logic [SELW-1:0] start,
    output logic [NCH-1:0]  grant
);

    logic [2*NCH-1:0] validDbl;
    logic [2*NCH-1:0] validShift;
    logic [NCH-1:0]   rotated;
    logic [NCH-1:0]   pickRot;
    logic [2*NCH-1:0] grantDbl;

    // Rotate so that channel 'start' sits at bit 0, isolate the lowest set
    // bit, then rotate the one-hot result back into channel positions.
    always_comb begin
        validDbl   = {valid, valid};
        validShift = validDbl >> start;
        rotated    = validShift[NCH-1:0];
        pickRot    = rotated & (~rotated + NCH'(1));
        grantDbl   = {pickRot, pickRot} << start;
        grant      = grantDbl[2*NCH-1:NCH];
    end

endmodule

// File: rtl/riscv_arb_mux.sv
// N-channel valid/ready selector feeding one registered output stage.
// Selection is steered by i_sel, fixed priority, or round-robin depending
// on MODE; the output register drains and reloads in the same cycle.
module riscv_arb_mux
    import riscv_arb_mux_pkg::*;
#(
    parameter int XLEN = CORE_XLEN,
    parameter int NCH  = 4,
    parameter int MODE = MUX_MODE_STEER,
    parameter int SELW = $clog2(NCH)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [NCH-1:0]      i_valid,
    output logic [NCH-1:0]      o_ready,
    input  logic [NCH*XLEN-1:0] i_data,
    input  logic [SELW-1:0]     i_sel,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [XLEN-1:0]     o_data,
    output logic [SELW-1:0]     o_idx
);

    logic            canLoad;
    logic [SELW-1:0] rrPtr;
    logic [SELW-1:0] pickStart;
    logic [NCH-1:0]  pickGrant;
    logic [NCH-1:0]  steerGrant;
    logic [NCH-1:0]  grant;
    logic [SELW-1:0] grantIdx;
    logic [XLEN-1:0] grantData;
    logic            fire;

    assign canLoad   = !o_valid || i_ready;
    assign pickStart = (MODE == MUX_MODE_RR) ? rrPtr : '0;

    riscv_rr_pick #(
        .NCH  (NCH),
        .SELW (SELW)
    ) u_pick (
        .valid (i_valid),
        .start (pickStart),
        .grant (pickGrant)
    );

    // Steered candidate: only the channel named by i_sel, and only if valid.
    // An out-of-range i_sel matches no channel and so grants nothing.
    always_comb begin
        steerGrant = '0;
        for (int k = 0; k < NCH; k++) begin
            steerGrant[k] = i_valid[k] && (i_sel == SELW'(k));
        end
    end

    // Mode select for the grant, and the handshake: no accept while the
    // output is stalled or while reset is held.
    always_comb begin
        grant   = (MODE == MUX_MODE_STEER) ? steerGrant : pickGrant;
        o_ready = (canLoad && !i_rst) ? grant : '0;
        fire    = |o_ready;
    end

    // One-hot grant to channel index and the matching data word.
    always_comb begin
        grantIdx  = '0;
        grantData = '0;
        for (int k = 0; k < NCH; k++) begin
            if (grant[k]) begin
                grantIdx  = SELW'(k);
                grantData = i_data[k*XLEN +: XLEN];
            end
        end
    end

    // Output register and round-robin pointer: load on an accepted
    // transfer, empty when drained with nothing to replace it, else hold.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_idx   <= '0;
            rrPtr   <= '0;
        end else if (fire) begin
            o_valid <= 1'b1;
            o_data  <= grantData;
            o_idx   <= grantIdx;
            rrPtr   <= SELW'(wrapInc(int'(grantIdx), NCH));
        end else if (canLoad && i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_riscv_arb_mux.sv
// Bench for riscv_arb_mux: one instance per selection mode on shared
// inputs, checked every cycle against a behavioural model, plus directed
// expectations for the steering, priority, round-robin and stall cases.
module tb_riscv_arb_mux;

    localparam int NCH  = 4;
    localparam int XLEN = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    valid;
    logic [127:0]  data;
    logic [1:0]    sel;
    logic          ready;

    logic [3:0]    ordy [3];
    logic          ov   [3];
    logic [31:0]   od   [3];
    logic [1:0]    oi   [3];

    int checks = 0;
    int errors = 0;

    logic          mValid [3];
    logic [31:0]   mData  [3];
    int            mIdx   [3];
    int            mPtr;

    always #5 clk = ~clk;

    for (genvar m = 0; m < 3; m++) begin : g_dut
        riscv_arb_mux #(
            .XLEN (XLEN),
            .NCH  (NCH),
            .MODE (m)
        ) dut (
            .i_clk   (clk),
            .i_rst   (rst),
            .i_valid (valid),
            .o_ready (ordy[m]),
            .i_data  (data),
            .i_sel   (sel),
            .o_valid (ov[m]),
            .i_ready (ready),
            .o_data  (od[m]),
            .o_idx   (oi[m])
        );
    end

    // Single comparison point: counts every check, reports any difference.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Which channel the mode's rule selects, or -1 when there is none.
    function automatic int pickChannel(input int mode, input logic [3:0] v, input logic [1:0] s, input int ptr);
        int c;
        if (mode == 0) begin
            return (int'(s) < NCH && v[s]) ? int'(s) : -1;
        end
        for (int off = 0; off < NCH; off++) begin
            c = (mode == 2) ? (ptr + off) % NCH : off;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [127:0] mkData(input logic [31:0] base);
        logic [127:0] d;
        for (int k = 0; k < NCH; k++) d[k*32 +: 32] = base + 32'(k);
        return d;
    endfunction

    // Drive one cycle of inputs, compare all three instances against the
    // model, then advance the model across the clock edge.
    task automatic applyStimulus(input logic [3:0] v, input logic [127:0] d, input logic [1:0] s,
                                 input logic r, input logic rs);
        int         ch   [3];
        logic       fire [3];
        logic       cl   [3];
        logic [3:0] expRdy;
        @(negedge clk);
        valid = v;
        data  = d;
        sel   = s;
        ready = r;
        rst   = rs;
        #1;
        for (int m = 0; m < 3; m++) begin
            ch[m]  = pickChannel(m, v, s, mPtr);
            cl[m]  = !mValid[m] || r;
            expRdy = (cl[m] && !rs && ch[m] >= 0) ? 4'(1 << ch[m]) : 4'b0;
            fire[m] = (expRdy != 4'b0);
            checkOutput($sformatf("m%0d_o_ready", m), 64'(ordy[m]), 64'(expRdy));
            checkOutput($sformatf("m%0d_o_valid", m), 64'(ov[m]),   64'(mValid[m]));
            checkOutput($sformatf("m%0d_o_data", m),  64'(od[m]),   64'(mData[m]));
            checkOutput($sformatf("m%0d_o_idx", m),   64'(oi[m]),   64'(mIdx[m]));
        end
        @(posedge clk);
        for (int m = 0; m < 3; m++) begin
            if (rs) begin
                mValid[m] = 1'b0;
                mData[m]  = '0;
                mIdx[m]   = 0;
            end else if (fire[m]) begin
                mValid[m] = 1'b1;
                mData[m]  = d[ch[m]*32 +: 32];
                mIdx[m]   = ch[m];
                if (m == 2) mPtr = (ch[m] + 1) % NCH;
            end else if (cl[m] && r) begin
                mValid[m] = 1'b0;
            end
        end
        if (rs) mPtr = 0;
    endtask

    initial begin
        logic [127:0] base;
        logic [127:0] rd;
        base = mkData(32'h1000);

        // Bring registers out of X before anything is compared.
        valid = 4'b1111;
        data  = base;
        sel   = 2'd0;
        ready = 1'b1;
        rst   = 1'b1;
        @(posedge clk);
        #1;
        for (int m = 0; m < 3; m++) begin
            mValid[m] = 1'b0;
            mData[m]  = '0;
            mIdx[m]   = 0;
        end
        mPtr = 0;

        // Reset held two cycles with every channel requesting.
        applyStimulus(4'b1111, base, 2'd2, 1'b1, 1'b1);
        applyStimulus(4'b1111, base, 2'd2, 1'b1, 1'b1);
        #1;
        for (int m = 0; m < 3; m++) begin
            checkOutput($sformatf("rst_valid_m%0d", m), 64'(ov[m]), 64'd0);
            checkOutput($sformatf("rst_data_m%0d", m),  64'(od[m]), 64'd0);
        end

        // First cycle after release: steer to 2, priority/rr start at 0.
        applyStimulus(4'b1111, base, 2'd2, 1'b1, 1'b0);
        #1;
        checkOutput("steer_data", 64'(od[0]), 64'h1002);
        checkOutput("steer_idx",  64'(oi[0]), 64'd2);
        checkOutput("prio_first", 64'(oi[1]), 64'd0);
        checkOutput("rr_first",   64'(oi[2]), 64'd0);

        // Round-robin over all-valid: 1,2,3,0 with no bubbles.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'b1111, base, 2'd2, 1'b1, 1'b0);
            #1;
            checkOutput("rr_seq_idx",   64'(oi[2]), 64'((i + 1) % 4));
            checkOutput("rr_seq_valid", 64'(ov[2]), 64'd1);
        end

        // Steered channel goes idle: output empties after the drain.
        applyStimulus(4'b1011, base, 2'd2, 1'b1, 1'b0);
        #1;
        checkOutput("steer_empty", 64'(ov[0]), 64'd0);

        // Priority: channel 1 beats 3 while valid, then 3 alone.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b1010, base, 2'd2, 1'b1, 1'b0);
            #1;
            checkOutput("prio_ch1", 64'(oi[1]), 64'd1);
        end
        applyStimulus(4'b1000, base, 2'd2, 1'b1, 1'b0);
        #1;
        checkOutput("prio_ch3", 64'(oi[1]), 64'd3);

        // Backpressure for three cycles, then drain and reload together.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b1111, mkData(32'h2000), 2'd1, 1'b0, 1'b0);
        end
        #1;
        checkOutput("stall_prio_idx",  64'(oi[1]), 64'd3);
        checkOutput("stall_prio_data", 64'(od[1]), 64'h1003);
        applyStimulus(4'b1111, mkData(32'h2000), 2'd1, 1'b1, 1'b0);
        #1;
        checkOutput("release_prio_data", 64'(od[1]), 64'h2000);
        checkOutput("release_valid",     64'(ov[1]), 64'd1);

        // Wrap-around: serve channel 2, then only channel 0 requests.
        applyStimulus(4'b0100, base, 2'd0, 1'b1, 1'b0);
        #1;
        checkOutput("wrap_pre_idx", 64'(oi[2]), 64'd2);
        applyStimulus(4'b0001, base, 2'd0, 1'b1, 1'b0);
        #1;
        checkOutput("wrap_idx", 64'(oi[2]), 64'd0);
        applyStimulus(4'b0011, base, 2'd0, 1'b1, 1'b0);
        #1;
        checkOutput("wrap_ptr_next", 64'(oi[2]), 64'd1);

        // Reset in the middle of back-to-back transfers.
        applyStimulus(4'b1111, base, 2'd3, 1'b1, 1'b1);
        #1;
        for (int m = 0; m < 3; m++) begin
            checkOutput($sformatf("midrst_valid_m%0d", m), 64'(ov[m]), 64'd0);
        end

        // Randomised traffic with backpressure and occasional reset.
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < NCH; k++) rd[k*32 +: 32] = $urandom;
            applyStimulus(4'($urandom_range(0, 15)), rd, 2'($urandom_range(0, 3)),
                          ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
